// File: rtl/bss_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bss_sub_seq
//  Purpose  : Multi-cycle chunked subtractor. It computes r = a - b - bw,
//             CHUNK_WIDTH bits per cycle, starting from the LSB chunk. Each
//             chunk computes both borrow-0 and borrow-1 differences, and the
//             running borrow selects one of them. Valid/ready handshakes sit
//             on both sides.
//  Ports    : clk_i, rst_i    - clock, synchronous active-high reset
//             valid_i/ready_o - request handshake (ready_o high in IDLE)
//             a_i, b_i, bw_i  - minuend, subtrahend, borrow in
//             valid_o/ready_i - result handshake (valid_o high in DONE)
//             r_o, bw_o       - difference, borrow out
//             z_o, v_o        - zero flag, signed overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module bss_sub_seq #(
   parameter int WORD_WIDTH  = 8,
   parameter int CHUNK_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [WORD_WIDTH-1:0] a_i,
   input  logic [WORD_WIDTH-1:0] b_i,
   input  logic                  bw_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [WORD_WIDTH-1:0] r_o,
   output logic                  bw_o,
   output logic                  z_o,
   output logic                  v_o
);

   localparam int N     = WORD_WIDTH / CHUNK_WIDTH;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int MSB   = WORD_WIDTH - 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic                   borrow;
   logic [WORD_WIDTH-1:0]  a_reg;
   logic [WORD_WIDTH-1:0]  b_reg;
   logic [WORD_WIDTH-1:0]  r_work;
   logic [WORD_WIDTH-1:0]  r_next;
   logic [WORD_WIDTH-1:0]  r_out;
   logic                   bw_out;
   logic                   z_out;
   logic                   v_out;
   logic                   last;
   int                     chunk_lo;
   logic [CHUNK_WIDTH-1:0] a_chunk;
   logic [CHUNK_WIDTH-1:0] b_chunk;
   logic [CHUNK_WIDTH:0]   diff0;
   logic [CHUNK_WIDTH:0]   diff1;
   logic [CHUNK_WIDTH:0]   diff_sel;

   assign last     = (cnt == LAST);
   assign chunk_lo = int'(cnt) * CHUNK_WIDTH;
   assign a_chunk  = a_reg[chunk_lo +: CHUNK_WIDTH];
   assign b_chunk  = b_reg[chunk_lo +: CHUNK_WIDTH];

   // The extra top bit of each candidate is that chunk's borrow out.
   assign diff0    = {1'b0, a_chunk} - {1'b0, b_chunk};
   assign diff1    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK_WIDTH{1'b0}}, 1'b1};
   assign diff_sel = borrow ? diff1 : diff0;

   // The working result with the current chunk merged in. On the last chunk
   // this is the complete difference, and the flags are derived from it.
   always_comb begin
      r_next                           = r_work;
      r_next[chunk_lo +: CHUNK_WIDTH]  = diff_sel[CHUNK_WIDTH-1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid_i) state_nxt = BUSY;
         BUSY:    if (last)    state_nxt = DONE;
         DONE:    if (ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         borrow <= 1'b0;
         a_reg  <= '0;
         b_reg  <= '0;
         r_work <= '0;
         r_out  <= '0;
         bw_out <= 1'b0;
         z_out  <= 1'b0;
         v_out  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (valid_i) begin
                  a_reg  <= a_i;
                  b_reg  <= b_i;
                  borrow <= bw_i;
                  cnt    <= '0;
               end
            end
            BUSY: begin
               r_work <= r_next;
               borrow <= diff_sel[CHUNK_WIDTH];
               if (!last) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  // Visible outputs change only here, so they hold their last
                  // values throughout IDLE and BUSY.
                  r_out  <= r_next;
                  bw_out <= diff_sel[CHUNK_WIDTH];
                  z_out  <= ~|r_next;
                  v_out  <= (a_reg[MSB] != b_reg[MSB]) & (r_next[MSB] != a_reg[MSB]);
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o = (state == IDLE);
   assign valid_o = (state == DONE);
   assign r_o     = r_out;
   assign bw_o    = bw_out;
   assign z_o     = z_out;
   assign v_o     = v_out;

endmodule
`default_nettype wire

// File: tb/tb_bss_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bss_sub_seq
//  Purpose  : Self-checking bench for bss_sub_seq. It runs three instances
//             with WORD_WIDTH=8 and CHUNK_WIDTH of 1, 4 and 8. An arithmetic
//             reference model checks every cycle. Directed cases with literal
//             results run on the 4-bit-chunk lane.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bss_sub_seq;

   localparam int NL = 3;

   logic       clk;
   logic       rst;
   logic [7:0] a_s  [NL];
   logic [7:0] b_s  [NL];
   logic       bw_s [NL];
   logic       vi_s [NL];
   logic       ri_s [NL];
   logic       rdy  [NL];
   logic       vo   [NL];
   logic [7:0] ro   [NL];
   logic       bwo  [NL];
   logic       zo   [NL];
   logic       vvo  [NL];

   int checks   = 0;
   int failures = 0;
   bit started  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar L = 0; L < NL; L++) begin : g_lane
      localparam int CW  = (L == 0) ? 1 : ((L == 1) ? 4 : 8);
      localparam int NCH = 8 / CW;

      bss_sub_seq #(.WORD_WIDTH(8), .CHUNK_WIDTH(CW)) u_dut (
         .clk_i   (clk),
         .rst_i   (rst),
         .valid_i (vi_s[L]),
         .ready_o (rdy[L]),
         .a_i     (a_s[L]),
         .b_i     (b_s[L]),
         .bw_i    (bw_s[L]),
         .valid_o (vo[L]),
         .ready_i (ri_s[L]),
         .r_o     (ro[L]),
         .bw_o    (bwo[L]),
         .z_o     (zo[L]),
         .v_o     (vvo[L])
      );

      // Reference model. phase is 0 while waiting for a request, 1 while the
      // result is being computed (left counts down the remaining cycles),
      // and 2 while the result is offered.
      int         phase = 0;
      int         left  = 0;
      int         diff;
      logic [7:0] er    = 8'h00;
      logic       ebw   = 1'b0;
      logic       ez    = 1'b0;
      logic       ev    = 1'b0;
      bit         fresh = 1'b1;

      always @(posedge clk) begin
         if (rst) begin
            phase = 0;
            er    = 8'h00;
            ebw   = 1'b0;
            ez    = 1'b0;
            ev    = 1'b0;
            fresh = 1'b1;
         end else begin
            case (phase)
               0: if (vi_s[L]) begin
                  diff  = int'(a_s[L]) - int'(b_s[L]) - int'(bw_s[L]);
                  er    = diff[7:0];
                  ebw   = (int'(a_s[L]) < int'(b_s[L]) + int'(bw_s[L]));
                  ez    = (er == 8'h00);
                  ev    = (a_s[L][7] != b_s[L][7]) && (er[7] != a_s[L][7]);
                  left  = NCH;
                  phase = 1;
                  fresh = 1'b0;
               end
               1: begin
                  left--;
                  if (left == 0) phase = 2;
               end
               default: if (ri_s[L]) phase = 0;
            endcase
         end
      end

      always @(posedge clk) begin
         #1;
         if (started) begin
            chk($sformatf("lane%0d ready_o", L), 32'(rdy[L]), 32'(phase == 0));
            chk($sformatf("lane%0d valid_o", L), 32'(vo[L]),  32'(phase == 2));
            if (phase == 2 || (phase == 0 && fresh)) begin
               chk($sformatf("lane%0d r_o", L),  32'(ro[L]),  32'(er));
               chk($sformatf("lane%0d bw_o", L), 32'(bwo[L]), 32'(ebw));
               chk($sformatf("lane%0d z_o", L),  32'(zo[L]),  32'(ez));
               chk($sformatf("lane%0d v_o", L),  32'(vvo[L]), 32'(ev));
            end
         end
      end
   end

   // Directed helpers act on lane 1, which uses 4-bit chunks, so N=2.
   task automatic wait_idle();
      int g = 0;
      while (!rdy[1] && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("wait idle", 32'(rdy[1]), 32'd1);
   endtask

   task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bw, output int lat);
      wait_idle();
      a_s[1]  = a;
      b_s[1]  = b;
      bw_s[1] = bw;
      vi_s[1] = 1'b1;
      @(negedge clk);
      vi_s[1] = 1'b0;
      lat = 0;
      while (!vo[1] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_result();
      ri_s[1] = 1'b1;
      @(negedge clk);
      ri_s[1] = 1'b0;
   endtask

   task automatic expect_res(input string nm, input logic [7:0] r, input logic bw,
                             input logic z, input logic v);
      chk({nm, " valid"}, 32'(vo[1]),  32'd1);
      chk({nm, " r"},     32'(ro[1]),  32'(r));
      chk({nm, " bw"},    32'(bwo[1]), 32'(bw));
      chk({nm, " z"},     32'(zo[1]),  32'(z));
      chk({nm, " v"},     32'(vvo[1]), 32'(v));
   endtask

   initial begin
      int lat;
      int prev;
      int nacc;
      rst = 1'b1;
      for (int i = 0; i < NL; i++) begin
         a_s[i] = 8'h00; b_s[i] = 8'h00; bw_s[i] = 1'b0;
         vi_s[i] = 1'b0; ri_s[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      started = 1'b1;

      // Values immediately after reset.
      chk("reset ready", 32'(rdy[1]), 32'd1);
      chk("reset valid", 32'(vo[1]),  32'd0);
      chk("reset r",     32'(ro[1]),  32'd0);
      chk("reset bw",    32'(bwo[1]), 32'd0);
      chk("reset z",     32'(zo[1]),  32'd0);
      chk("reset v",     32'(vvo[1]), 32'd0);

      op(8'h35, 8'h12, 1'b0, lat);
      chk("basic latency", 32'(lat), 32'd2);
      expect_res("basic", 8'h23, 1'b0, 1'b0, 1'b0);
      release_result();

      op(8'h00, 8'h01, 1'b0, lat);
      expect_res("underflow", 8'hFF, 1'b1, 1'b0, 1'b0);
      release_result();

      op(8'h80, 8'h01, 1'b0, lat);
      expect_res("overflow", 8'h7F, 1'b0, 1'b0, 1'b1);
      release_result();

      op(8'h10, 8'h0F, 1'b1, lat);
      expect_res("chunk borrow", 8'h00, 1'b0, 1'b1, 1'b0);
      release_result();

      // Backpressure: the result must hold for 5 cycles with ready_i low.
      op(8'h35, 8'h12, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         expect_res("hold", 8'h23, 1'b0, 1'b0, 1'b0);
      end
      release_result();

      // A second request during BUSY must be ignored.
      wait_idle();
      a_s[1] = 8'h44; b_s[1] = 8'h11; bw_s[1] = 1'b0; vi_s[1] = 1'b1;
      @(negedge clk);
      a_s[1] = 8'hFF; b_s[1] = 8'h00; bw_s[1] = 1'b1; vi_s[1] = 1'b1;
      @(negedge clk);
      vi_s[1] = 1'b0;
      lat = 0;
      while (!vo[1] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      expect_res("busy ignore", 8'h33, 1'b0, 1'b0, 1'b0);
      release_result();

      // Reset during the first BUSY cycle discards the operation.
      wait_idle();
      a_s[1] = 8'h35; b_s[1] = 8'h12; bw_s[1] = 1'b0; vi_s[1] = 1'b1;
      @(negedge clk);
      vi_s[1] = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      chk("midbusy rst ready", 32'(rdy[1]), 32'd1);
      chk("midbusy rst valid", 32'(vo[1]),  32'd0);
      chk("midbusy rst r",     32'(ro[1]),  32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post rst valid", 32'(vo[1]), 32'd0);
      end

      // A request that arrives together with reset must not be taken.
      a_s[1] = 8'h55; b_s[1] = 8'h11; vi_s[1] = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; vi_s[1] = 1'b0;
      @(negedge clk);
      chk("rst+valid ready", 32'(rdy[1]), 32'd1);

      // Back-to-back operations with both handshakes held high.
      wait_idle();
      vi_s[1] = 1'b1;
      ri_s[1] = 1'b1;
      prev = -1;
      nacc = 0;
      for (int c = 0; c < 16; c++) begin
         if (rdy[1]) begin
            if (prev >= 0) chk("b2b spacing", 32'(c - prev), 32'd4);
            prev = c;
            nacc++;
         end
         a_s[1]  = 8'($urandom);
         b_s[1]  = 8'($urandom);
         bw_s[1] = 1'($urandom);
         @(negedge clk);
      end
      chk("b2b count", 32'(nacc), 32'd4);
      vi_s[1] = 1'b0;

      // Randomized traffic on all three lanes.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NL; i++) begin
            a_s[i]  = 8'($urandom);
            b_s[i]  = 8'($urandom);
            bw_s[i] = 1'($urandom);
            vi_s[i] = 1'($urandom);
            ri_s[i] = ($urandom_range(0, 3) != 0);
         end
         @(negedge clk);
      end
      for (int i = 0; i < NL; i++) begin
         vi_s[i] = 1'b0;
         ri_s[i] = 1'b1;
      end
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bss_sub_seq.md
BSS_SUB_SEQ -- requirements
Module: bss_sub_seq

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 8, giving the operand and result width.
REQ-002 The block SHALL have parameter CHUNK_WIDTH, default 4, giving the bits processed per cycle; WORD_WIDTH SHALL be an integer multiple of CHUNK_WIDTH, and N = WORD_WIDTH/CHUNK_WIDTH.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port valid_i, input, 1 bit: an operation request is present.
REQ-006 Port ready_o, output, 1 bit: the block can accept a request.
REQ-007 Port a_i, input, WORD_WIDTH: minuend.
REQ-008 Port b_i, input, WORD_WIDTH: subtrahend.
REQ-009 Port bw_i, input, 1 bit: borrow in.
REQ-010 Port valid_o, output, 1 bit: a result is present.
REQ-011 Port ready_i, input, 1 bit: the consumer accepts the result.
REQ-012 Port r_o, output, WORD_WIDTH: difference a - b - bw, modulo 2^WORD_WIDTH.
REQ-013 Port bw_o, output, 1 bit: borrow out (1 when the unsigned a < b + bw).
REQ-014 Port z_o, output, 1 bit: 1 when r_o == 0.
REQ-015 Port v_o, output, 1 bit: signed overflow of the subtraction.

Function
REQ-016 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-017 In IDLE, ready_o SHALL be 1; in BUSY and DONE it SHALL be 0.
REQ-018 In IDLE, when valid_i=1 on a rising edge, the block SHALL:
- capture a_i, b_i and bw_i into internal registers;
- clear the chunk counter;
- load the borrow register with bw_i;
- go to BUSY.
REQ-019 Inputs a_i, b_i, bw_i and valid_i SHALL be ignored in BUSY and DONE; captured operands SHALL NOT change until the next acceptance.
REQ-020 In each BUSY cycle, the block SHALL process chunk k, from bits [(k+1)*CHUNK_WIDTH-1 : k*CHUNK_WIDTH], starting at the LSB chunk:
- compute both candidates, a_k - b_k with borrow 0 and with borrow 1;
- select one with the borrow register;
- write the selected chunk into the result register;
- load the selected chunk borrow into the borrow register;
- increment the counter.
REQ-021 When the counter equals N-1 in BUSY, after that chunk is processed the block SHALL go to DONE; BUSY SHALL therefore last exactly N cycles, including N=1.
REQ-022 valid_o SHALL be 1 exactly when in DONE; it SHALL first assert N clock cycles after the accepting edge.
REQ-023 In DONE, r_o, bw_o, z_o and v_o SHALL all be driven from registers.
REQ-024 In DONE, r_o, bw_o, z_o and v_o SHALL be stable while ready_i=0, for an unlimited number of cycles.
REQ-025 In DONE, when ready_i=1 on a rising edge, the block SHALL go to IDLE; a new request SHALL be acceptable no earlier than the following edge.
REQ-026 bw_o SHALL equal the borrow register after the final chunk.
REQ-027 v_o SHALL equal (a[MSB] != b[MSB]) & (r[MSB] != a[MSB]), using the captured operands.
REQ-028 z_o SHALL be the NOR of all result bits.
REQ-029 In IDLE and BUSY, r_o, bw_o, z_o and v_o SHALL hold their last values; their value outside DONE SHALL NOT be relied on, except after reset (REQ-030).

Reset
REQ-030 When rst_i=1 on a rising edge, the block SHALL:
- go to IDLE;
- clear the counter, the borrow register, the operand registers and the result register;
- after that edge, drive ready_o=1, valid_o=0, r_o=0, bw_o=0, z_o=0 and v_o=0.
REQ-031 rst_i SHALL override every other input in any state, including mid-BUSY and DONE; any in-flight result SHALL be discarded, and no valid_o pulse SHALL follow.
REQ-032 A valid_i asserted in the same cycle as rst_i SHALL NOT be accepted.

Verification (WORD_WIDTH=8, CHUNK_WIDTH=4, N=2)
REQ-033 The bench SHALL cover this case: a=0x35, b=0x12, bw=0 -> r=0x23, bw_o=0, z=0, v=0, with valid_o asserting 2 cycles after acceptance.
REQ-034 The bench SHALL cover these cases:
- a=0x00, b=0x01, bw=0 -> r=0xFF, bw_o=1, z=0, v=0;
- a=0x80, b=0x01, bw=0 -> r=0x7F, bw_o=0, v=1.
REQ-035 The bench SHALL cover this case, a borrow crossing a chunk boundary: a=0x10, b=0x0F, bw=1 -> r=0x00, z=1, bw_o=0, v=0.
REQ-036 The bench SHALL cover backpressure:
- hold ready_i=0 for 5 cycles in DONE -> valid_o stays 1 and r_o, bw_o, z_o, v_o are unchanged;
- pulse valid_i with different operands during BUSY -> ignored, and the result matches the first operands.
REQ-037 The bench SHALL cover rst_i=1 for one cycle during the first BUSY cycle -> next cycle ready_o=1, valid_o=0, r_o=0x00, and valid_o stays 0 for at least 4 cycles afterwards.
REQ-038 The bench SHALL run back-to-back operations with ready_i=1 held and valid_i=1 held -> one acceptance every N+2 cycles and the results are correct; it SHALL also run a randomized comparison against a-b-bw for CHUNK_WIDTH in {1, 4, 8}.
